// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the register-file write arbiter and its MDU buffer.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    // One buffered MDU result. A killed entry still occupies its slot until it
    // reaches the head, where it is discarded without touching the write port.
    typedef struct packed {
        logic     valid;
        logic     killed;
        regbits_t wsel;
        word_t    wdat;
    } rfwa_entry_t;

endpackage

// File: rtl/rfwa_fifo.sv
// In-order MDU result buffer with kill-by-destination and destination
// match outputs for two read selects. The caller never pushes when full
// and never pops when empty.
module rfwa_fifo
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  regbits_t                 push_wsel,
    input  word_t                    push_wdat,
    input  logic                     pop,
    input  logic                     kill,
    input  regbits_t                 kill_wsel,
    input  regbits_t                 rsel1,
    input  regbits_t                 rsel2,
    output rfwa_entry_t              head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     match1,
    output logic                     match2
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    rfwa_entry_t   mem [DEPTH];
    logic [PW-1:0] head_ptr;
    logic [PW-1:0] tail_ptr;

    assign head = mem[head_ptr];

    // Storage update: kill marks first, then pop clears the head slot, then
    // push fills the tail slot (pointers wrap naturally at a power of two).
    always_ff @(posedge clk) begin
        if (rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (kill) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (mem[i].valid && (mem[i].wsel == kill_wsel)) begin
                        mem[i].killed <= 1'b1;
                    end
                end
            end
            if (pop) begin
                mem[head_ptr].valid  <= 1'b0;
                mem[head_ptr].killed <= 1'b0;
                head_ptr             <= head_ptr + 1'b1;
            end
            if (push) begin
                mem[tail_ptr] <= '{valid: 1'b1, killed: 1'b0, wsel: push_wsel, wdat: push_wdat};
                tail_ptr      <= tail_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Live-entry destination match for the two decode read selects.
    always_comb begin
        match1 = 1'b0;
        match2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i].valid && !mem[i].killed && (mem[i].wsel == rsel1)) match1 = 1'b1;
            if (mem[i].valid && !mem[i].killed && (mem[i].wsel == rsel2)) match2 = 1'b1;
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback
// (priority) and buffered MDU results, with a starvation-driven forced drain,
// kill of stale MDU results, and pending-write reporting for hazard checks.
module rf_write_arbiter
    import cpu_types_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic     CLK,
    input  logic     nRST,
    input  logic     wb_valid,
    input  regbits_t wb_wsel,
    input  word_t    wb_wdat,
    output logic     wb_ready,
    input  logic     mdu_valid,
    input  regbits_t mdu_wsel,
    input  word_t    mdu_wdat,
    output logic     mdu_ready,
    output logic     rf_WEN,
    output regbits_t rf_wsel,
    output word_t    rf_wdat,
    input  regbits_t rsel1,
    input  regbits_t rsel2,
    output logic     pend_hit1,
    output logic     pend_hit2
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    rfwa_entry_t   head;
    logic [CW-1:0] count;
    logic          match1;
    logic          match2;
    logic [SW-1:0] starve_cnt;

    logic live_head;
    logic dead_head;
    logic drain;
    logic grant_head;
    logic grant_wb;
    logic grant_byp;
    logic mdu_acc;
    logic mdu_drop;
    logic push;
    logic pop;
    logic kill;

    // Forced to 1 while reset is asserted so upstream never stalls on stale state.
    assign wb_ready  = nRST || !drain;
    assign mdu_ready = nRST || (count < FULL_COUNT);

    assign pend_hit1 = (rsel1 != '0) && (match1 || (rf_WEN && (rf_wsel == rsel1)));
    assign pend_hit2 = (rsel2 != '0) && (match2 || (rf_WEN && (rf_wsel == rsel2)));

    // Grant selection: drain > pipeline > live head > empty-buffer bypass.
    always_comb begin
        live_head  = head.valid && !head.killed;
        dead_head  = head.valid && head.killed;
        drain      = live_head && (starve_cnt == STARVE_MAX);
        grant_head = drain || (!wb_valid && live_head);
        grant_wb   = !drain && wb_valid;
        grant_byp  = !drain && !wb_valid && (count == '0) && mdu_valid;
        mdu_acc    = mdu_valid && mdu_ready;
        mdu_drop   = mdu_acc && grant_wb && (wb_wsel != '0) && (wb_wsel == mdu_wsel);
        push       = mdu_acc && !mdu_drop && !grant_byp;
        pop        = grant_head || dead_head;
        kill       = grant_wb && (wb_wsel != '0);
    end

    rfwa_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (CLK),
        .rst       (nRST),
        .push      (push),
        .push_wsel (mdu_wsel),
        .push_wdat (mdu_wdat),
        .pop       (pop),
        .kill      (kill),
        .kill_wsel (wb_wsel),
        .rsel1     (rsel1),
        .rsel2     (rsel2),
        .head      (head),
        .count     (count),
        .match1    (match1),
        .match2    (match2)
    );

    // Starvation counter: a killed head holds the count so the entry behind it
    // inherits the wait already accumulated.
    always_ff @(posedge CLK) begin
        if (nRST) begin
            starve_cnt <= '0;
        end else if (live_head) begin
            if (grant_head) begin
                starve_cnt <= '0;
            end else if (starve_cnt < STARVE_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end else if (!dead_head) begin
            starve_cnt <= '0;
        end
    end

    // Registered write port; register 0 writes are consumed with the enable low.
    always_ff @(posedge CLK) begin
        if (nRST) begin
            rf_WEN  <= 1'b0;
            rf_wsel <= '0;
            rf_wdat <= '0;
        end else if (grant_head) begin
            rf_WEN  <= (head.wsel != '0);
            rf_wsel <= head.wsel;
            rf_wdat <= head.wdat;
        end else if (grant_wb) begin
            rf_WEN  <= (wb_wsel != '0);
            rf_wsel <= wb_wsel;
            rf_wdat <= wb_wdat;
        end else if (grant_byp) begin
            rf_WEN  <= (mdu_wsel != '0);
            rf_wsel <= mdu_wsel;
            rf_wdat <= mdu_wdat;
        end else begin
            rf_WEN  <= 1'b0;
        end
    end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the single register-file write port between the pipeline writeback stage and the long-latency multiply/divide unit (MDU). Pipeline writes have priority; MDU results wait in a small in-order buffer, are guaranteed forward progress by a starvation limit, and are killed when a newer pipeline write targets the same register. The block also reports pending-write hits on the decode read selects so the hazard unit can stall.

## Interface
Parameters:
- DEPTH, 2: MDU buffer entries; power of two, ≥2.
- STARVE_LIMIT, 4: consecutive ungranted cycles of a live buffer head before a forced drain.

Ports:
- CLK  in  1  clock, all state on rising edge.
- nRST  in  1  synchronous, active-high reset (1 = reset, sampled on CLK).
- wb_valid  in  1  pipeline write request.
- wb_wsel  in  5  pipeline destination register.
- wb_wdat  in  32  pipeline write data (word_t).
- wb_ready  out  1  pipeline write accepted this cycle when high with wb_valid.
- mdu_valid  in  1  MDU result valid.
- mdu_wsel  in  5  MDU destination register.
- mdu_wdat  in  32  MDU result (word_t).
- mdu_ready  out  1  buffer can accept MDU result.
- rf_WEN  out  1  register-file write enable (registered).
- rf_wsel  out  5  register-file write select (registered).
- rf_wdat  out  32  register-file write data (registered).
- rsel1, rsel2  in  5  decode read selects.
- pend_hit1, pend_hit2  out  1  pending write exists for rsel1/rsel2.

## Operation
- Buffer: FIFO of DEPTH entries {valid, killed, wsel, wdat}; head/tail pointers wrap modulo DEPTH; count 0..DEPTH.
- mdu_ready = (count < DEPTH); combinational from state only.
- Per-cycle grant, in priority order:
  - DRAIN (starve counter == STARVE_LIMIT and live head): wb_ready = 0; head granted.
  - wb_valid: wb_ready = 1; pipeline granted.
  - live head present: head granted.
  - buffer empty and mdu_valid: MDU bypass granted directly, not enqueued.
- wb_ready = 1 whenever not in DRAIN (independent of wb_valid).
- Accepted MDU result not bypassed is enqueued at tail same edge.
- Kill rule: an accepted pipeline write to X≠0 sets killed on every buffer entry with wsel == X; an MDU result accepted the same cycle with wsel == X is dropped (not enqueued, not bypassed).
- Killed head is popped without using the port; it never asserts rf_WEN and does not reset the starve counter.
- Granted write with wsel == 0 is consumed but produces rf_WEN = 0.
- Starve counter: increments each cycle a live head exists and is not granted; clears when head granted or buffer has no live head; saturates at STARVE_LIMIT.
- pend_hitN = (rselN ≠ 0) and (rselN matches a valid, non-killed buffer entry, or rf_WEN && rf_wsel == rselN).
- Simultaneous enqueue and pop in same cycle when full: mdu_ready is 0 when full, so no enqueue; pop frees slot for next cycle.

## Timing
- Reset (nRST = 1 at edge): count, pointers, valid/killed bits, starve counter, rf_WEN, rf_wsel, rf_wdat all 0. During reset wb_ready = 1, mdu_ready = 1; inputs ignored. Reset mid-drain discards buffered results.
- Latency: grant in cycle N → rf_WEN/rf_wsel/rf_wdat valid in cycle N+1 for one cycle; register file updates at end of N+1.
- Enqueued MDU result: earliest issue is the cycle after enqueue.
- Max pipeline stall from DRAIN: 1 cycle per STARVE_LIMIT+1 cycles of contention.
- Throughput: one write per cycle.

## Structure
- cpu_types_pkg: word_t, regbits_t (5-bit), rfwa_entry_t struct {valid, killed, wsel, wdat}.
- Sub-module rfwa_fifo: DEPTH-entry FIFO with per-entry kill-by-wsel port and CAM match outputs for two selects; arbiter, starve counter and output registers stay in top.

## Test plan
- Reset: hold nRST = 1 two cycles with wb_valid = 1 → rf_WEN = 0, mdu_ready = 1, pend_hit1/2 = 0.
- Bypass: idle, mdu_valid wsel = 5 wdat = 0xDEAD → next cycle rf_WEN = 1, rf_wsel = 5, rf_wdat = 0xDEAD.
- Contention/starvation (STARVE_LIMIT = 4): wb_valid continuous to regs 1,2,…; MDU enqueues wsel = 9 → head ungranted 4 cycles, 5th cycle wb_ready = 0, following cycle rf_wsel = 9.
- Kill: MDU wsel = 7 buffered behind wb traffic; pipeline writes 7 with 0x1111 → only 0x1111 written to 7; buffered 7 never issued; pend_hit for 7 drops after pipeline write retires.
- Full/wrap: DEPTH = 2, wb_valid held, three MDU results → mdu_ready = 0 after two; drained in order; pointers wrap; third accepted once slot frees.
- Zero register and pend: MDU wsel = 0 → no rf_WEN; rsel1 = 0 → pend_hit1 = 0; buffered wsel = 3, rsel2 = 3 → pend_hit2 = 1 until write cycle ends.
